// File: rtl/regfile_mp.sv
// Multi-ported register file: two write ports, three combinational read ports with
// same-cycle write bypass, and a background sweep that clears every entry.
module regfile_mp #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int ZERO_R0 = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [ADDR_W-1:0] ra0,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd0,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              wr_conflict
);

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
    localparam logic [ADDR_W-1:0] IDX_ONE   = ADDR_W'(1);
    localparam bit                ZR        = (ZERO_R0 != 0);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state_r;
    logic [ADDR_W-1:0] clr_idx_r;
    logic              clr_busy_r;
    logic              clr_done_r;
    logic              wr_conflict_r;
    logic [DATA_W-1:0] mem_r [DEPTH];

    logic              wr0_s;
    logic              wr1_s;
    logic              conflict_s;
    logic [DATA_W-1:0] rd0_s;
    logic [DATA_W-1:0] rd1_s;
    logic [DATA_W-1:0] rd2_s;

    // Read mux: sweep forces zero, r0 is constant zero, then port 1 bypass beats port 0.
    function automatic logic [DATA_W-1:0] read_sel(
        input logic [ADDR_W-1:0] ra,
        input logic [DATA_W-1:0] stored,
        input logic              busy,
        input logic              wr0,
        input logic [ADDR_W-1:0] wa0,
        input logic [DATA_W-1:0] wd0,
        input logic              wr1,
        input logic [ADDR_W-1:0] wa1,
        input logic [DATA_W-1:0] wd1
    );
        logic [DATA_W-1:0] res;
        if (busy) begin
            res = '0;
        end else if (ZR && (ra == ADDR_ZERO)) begin
            res = '0;
        end else if (wr1 && (ra == wa1)) begin
            res = wd1;
        end else if (wr0 && (ra == wa0)) begin
            res = wd0;
        end else begin
            res = stored;
        end
        return res;
    endfunction

    // Effective write enables: sweep blocks all, r0 writes vanish, port 1 wins a same-address tie.
    always_comb begin
        wr1_s      = we1 && !clr_busy_r && !(ZR && (waddr1 == ADDR_ZERO));
        wr0_s      = we0 && !clr_busy_r && !(ZR && (waddr0 == ADDR_ZERO))
                     && !(we1 && (waddr1 == waddr0));
        conflict_s = we0 && we1 && (waddr0 == waddr1) && !clr_busy_r
                     && !(ZR && (waddr0 == ADDR_ZERO));
    end

    // Combinational read ports.
    always_comb begin
        rd0_s = read_sel(ra0, mem_r[ra0], clr_busy_r, wr0_s, waddr0, wdata0, wr1_s, waddr1, wdata1);
        rd1_s = read_sel(ra1, mem_r[ra1], clr_busy_r, wr0_s, waddr0, wdata0, wr1_s, waddr1, wdata1);
        rd2_s = read_sel(ra2, mem_r[ra2], clr_busy_r, wr0_s, waddr0, wdata0, wr1_s, waddr1, wdata1);
    end

    assign rd0         = rd0_s;
    assign rd1         = rd1_s;
    assign rd2         = rd2_s;
    assign clr_busy    = clr_busy_r;
    assign clr_done    = clr_done_r;
    assign wr_conflict = wr_conflict_r;

    // Storage array: sweep clears one entry per cycle, otherwise external writes land.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (clr_busy_r) begin
            mem_r[clr_idx_r] <= '0;
        end else begin
            if (wr0_s) begin
                mem_r[waddr0] <= wdata0;
            end
            if (wr1_s) begin
                mem_r[waddr1] <= wdata1;
            end
        end
    end

    // Clear sequencer and registered status flags; a request in the done cycle is ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= IDLE;
            clr_idx_r     <= '0;
            clr_busy_r    <= 1'b0;
            clr_done_r    <= 1'b0;
            wr_conflict_r <= 1'b0;
        end else begin
            wr_conflict_r <= conflict_s;
            case (state_r)
                IDLE: begin
                    clr_done_r <= 1'b0;
                    if (clr_req && !clr_done_r) begin
                        state_r    <= CLEAR;
                        clr_idx_r  <= '0;
                        clr_busy_r <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (clr_idx_r == LAST_IDX) begin
                        state_r    <= IDLE;
                        clr_idx_r  <= '0;
                        clr_busy_r <= 1'b0;
                        clr_done_r <= 1'b1;
                    end else begin
                        clr_idx_r <= clr_idx_r + IDX_ONE;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    clr_idx_r  <= '0;
                    clr_busy_r <= 1'b0;
                    clr_done_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: vector table for read/write/bypass/conflict/r0,
// then hand sequences for the clear sweep and reset during a sweep.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic        we0, we1;
    logic [4:0]  waddr0, waddr1;
    logic [31:0] wdata0, wdata1;
    logic [4:0]  ra0, ra1, ra2;
    logic [31:0] rd0, rd1, rd2;
    logic        clr_req;
    logic        clr_busy, clr_done, wr_conflict;

    int checks = 0;
    int errors = 0;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_R0(1)) dut (
        .clk(clk), .rst(rst),
        .we0(we0), .we1(we1), .waddr0(waddr0), .waddr1(waddr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .ra0(ra0), .ra1(ra1), .ra2(ra2),
        .rd0(rd0), .rd1(rd1), .rd2(rd2),
        .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done),
        .wr_conflict(wr_conflict)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we0;
        logic [4:0]  waddr0;
        logic [31:0] wdata0;
        logic        we1;
        logic [4:0]  waddr1;
        logic [31:0] wdata1;
        logic [4:0]  ra0, ra1, ra2;
        logic [31:0] e0, e1, e2;
        logic        econf;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        int busy_cnt, done_cnt, first_busy, last_busy, done_at;

        vecs[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 1'b0};
        vecs[1]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd5, 5'd5, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h12345678, 5'd7, 5'd5, 5'd7, 32'h12345678, 32'hDEADBEEF, 32'h12345678, 1'b0};
        vecs[3]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd9, 5'd0, 32'h12345678, 32'h0, 32'h0, 1'b0};
        vecs[4]  = '{1'b1, 5'd9, 32'h1, 1'b1, 5'd9, 32'h2, 5'd9, 5'd9, 5'd5, 32'h2, 32'h2, 32'hDEADBEEF, 1'b1};
        vecs[5]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd7, 5'd0, 32'h2, 32'h12345678, 32'h0, 1'b0};
        vecs[6]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd9, 32'h0, 32'h0, 32'h2, 1'b0};
        vecs[7]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd9, 5'd5, 32'h0, 32'h2, 32'hDEADBEEF, 1'b0};
        vecs[8]  = '{1'b1, 5'd3, 32'h0000AAAA, 1'b1, 5'd4, 32'h0000BBBB, 5'd3, 5'd4, 5'd5, 32'h0000AAAA, 32'h0000BBBB, 32'hDEADBEEF, 1'b0};
        vecs[9]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd4, 5'd0, 32'h0000AAAA, 32'h0000BBBB, 32'h0, 1'b0};
        vecs[10] = '{1'b1, 5'd4, 32'h0000CCCC, 1'b0, 5'd4, 32'h0000DDDD, 5'd4, 5'd3, 5'd4, 32'h0000CCCC, 32'h0000AAAA, 32'h0000CCCC, 1'b0};
        vecs[11] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd4, 5'd9, 5'd7, 32'h0000CCCC, 32'h2, 32'h12345678, 1'b0};

        rst = 1'b0; we0 = 1'b0; we1 = 1'b0; waddr0 = 5'd0; waddr1 = 5'd0;
        wdata0 = 32'h0; wdata1 = 32'h0; ra0 = 5'd5; ra1 = 5'd0; ra2 = 5'd31; clr_req = 1'b0;
        #12;
        check("reset_busy", {31'b0, clr_busy}, 32'h0);
        check("reset_done", {31'b0, clr_done}, 32'h0);
        check("reset_conflict", {31'b0, wr_conflict}, 32'h0);
        check("reset_rd0", rd0, 32'h0);
        check("reset_rd2", rd2, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        for (int v = 0; v < 12; v++) begin
            @(negedge clk);
            we0 = vecs[v].we0; waddr0 = vecs[v].waddr0; wdata0 = vecs[v].wdata0;
            we1 = vecs[v].we1; waddr1 = vecs[v].waddr1; wdata1 = vecs[v].wdata1;
            ra0 = vecs[v].ra0; ra1 = vecs[v].ra1; ra2 = vecs[v].ra2;
            #1;
            check($sformatf("vec%0d_rd0", v), rd0, vecs[v].e0);
            check($sformatf("vec%0d_rd1", v), rd1, vecs[v].e1);
            check($sformatf("vec%0d_rd2", v), rd2, vecs[v].e2);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_conflict", v), {31'b0, wr_conflict}, {31'b0, vecs[v].econf});
        end
        @(negedge clk);
        we0 = 1'b0; we1 = 1'b0;

        // Fill every writable entry with a nonzero value
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            we0 = 1'b1; waddr0 = 5'(i); wdata0 = 32'h100 + i;
        end
        @(negedge clk);
        we0 = 1'b0; ra0 = 5'd31; ra1 = 5'd1; ra2 = 5'd2;
        #1;
        check("fill_rd31", rd0, 32'h11F);
        check("fill_rd1", rd1, 32'h101);
        check("fill_rd2", rd2, 32'h102);

        // Clear sweep with a write, a conflict and stray requests issued during it
        clr_req = 1'b1;
        @(posedge clk);
        #1 clr_req = 1'b0;
        busy_cnt = 0; done_cnt = 0; first_busy = -1; last_busy = -1; done_at = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (clr_busy) begin
                busy_cnt++;
                if (first_busy < 0) first_busy = c;
                last_busy = c;
            end
            if (clr_done) begin
                done_cnt++;
                done_at = c;
            end
            we0 = 1'b0; we1 = 1'b0; clr_req = 1'b0;
            if (c == 5) begin
                we0 = 1'b1; waddr0 = 5'd2; wdata0 = 32'h55; ra0 = 5'd2;
                #1 check("sweep_bypass_off", rd0, 32'h0);
            end
            if (c == 7) begin
                we0 = 1'b1; we1 = 1'b1; waddr0 = 5'd8; waddr1 = 5'd8;
            end
            if (c == 8) check("sweep_conflict", {31'b0, wr_conflict}, 32'h0);
            if (c == 10 || c == 32) clr_req = 1'b1;
        end
        check("sweep_busy_cycles", busy_cnt, 32);
        check("sweep_first_busy", first_busy, 0);
        check("sweep_last_busy", last_busy, 31);
        check("sweep_done_count", done_cnt, 1);
        check("sweep_done_at", done_at, 32);
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i);
            #1 check($sformatf("cleared_%0d", i), rd1, 32'h0);
        end

        // Reset during a sweep
        @(negedge clk);
        we0 = 1'b1; waddr0 = 5'd25; wdata0 = 32'h55AA;
        @(negedge clk);
        we0 = 1'b0; ra0 = 5'd25;
        #1 check("pre_sweep_rd25", rd0, 32'h55AA);
        clr_req = 1'b1;
        @(posedge clk);
        #1 clr_req = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_sweep_busy", {31'b0, clr_busy}, 32'h1);
        rst = 1'b0;
        #1;
        check("abort_busy", {31'b0, clr_busy}, 32'h0);
        check("abort_done", {31'b0, clr_done}, 32'h0);
        check("abort_conflict", {31'b0, wr_conflict}, 32'h0);
        check("abort_rd25", rd0, 32'h0);
        @(negedge clk);
        rst = 1'b1; we0 = 1'b1; waddr0 = 5'd6; wdata0 = 32'h66;
        @(posedge clk);
        #1 we0 = 1'b0; ra0 = 5'd6;
        #1 check("first_write_after_reset", rd0, 32'h66);
        busy_cnt = 0; done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (clr_busy) busy_cnt++;
            if (clr_done) done_cnt++;
        end
        check("abort_no_done", done_cnt, 0);
        check("abort_no_busy", busy_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
